// File: rtl/exc_sequencer_pkg.sv
// Shared exception/interrupt definitions for the exception sequencer.
//   EXC_CODE_NONE  : ExcCode default meaning "no exception"
//   EXC_CODE_INT   : cause code reported for interrupts
//   EXC_HANDLER_PC : exception/interrupt entry PC
//   exc_state_e    : sequencer state encodings
package exc_sequencer_pkg;

  localparam logic [4:0]  EXC_CODE_NONE  = 5'd31;
  localparam logic [4:0]  EXC_CODE_INT   = 5'd0;
  localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and eret return sequencer for the 5-stage core.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   ExcCodeM          M-stage exception code (HANDLER taken when != EXC_NONE)
//   IntReq, EXL       CP0 pending interrupt request and EXL bit
//   IsEretM, EPC      eret in M stage and the CP0 return address
//   MDBusy            mult/div busy; a take waits (stalled) until it clears
//   EXLSet/EXLClr     one-cycle pulses to CP0
//   ExcCodeOut        cause latched at the take, held until the next take
//   FlushF..FlushM    pipeline register clears
//   StallAll          freeze PC and all pipeline registers
//   PCRedirect, NPC   NPC override and its target
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal flow; take or eret fire combinationally in this state
// ST_DRAIN | take pending, pipeline frozen until the mult/div unit is idle
// ST_FLUSH | post-take flush tail, counter runs down to 0
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = EXC_HANDLER_PC,
  parameter logic [4:0]  EXC_NONE     = EXC_CODE_NONE,
  parameter logic [4:0]  EXC_INT      = EXC_CODE_INT,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ExcCodeM,
  input  logic        IntReq,
  input  logic        EXL,
  input  logic        IsEretM,
  input  logic [31:0] EPC,
  input  logic        MDBusy,
  output logic        EXLSet,
  output logic [4:0]  ExcCodeOut,
  output logic        EXLClr,
  output logic        FlushF,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        StallAll,
  output logic        PCRedirect,
  output logic [31:0] NPC
);

  // The take cycle itself is the first flush cycle, so the tail is one shorter.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  exc_state_e state;
  logic [2:0] cnt;

  logic       tk;
  logic       er;
  logic [4:0] cause;
  logic       take;
  logic       eret;
  logic       stall;
  logic       flush_tail;

  always_comb begin
    tk         = ~EXL & (IntReq | (ExcCodeM != EXC_NONE));
    cause      = IntReq ? EXC_INT : ExcCodeM;
    er         = IsEretM & ~tk;
    take       = 1'b0;
    eret       = 1'b0;
    stall      = 1'b0;
    flush_tail = 1'b0;
    // Outputs are held quiet while Reset is sampled so nothing leaks to CP0.
    if (!Reset) begin
      case (state)
        ST_RUN: begin
          take  = tk & ~MDBusy;
          stall = tk & MDBusy;
          eret  = er;
        end
        ST_DRAIN: begin
          take  = tk & ~MDBusy;
          stall = ~take;
        end
        ST_FLUSH: flush_tail = 1'b1;
        default: ;
      endcase
    end
  end

  assign EXLSet     = take;
  assign EXLClr     = eret;
  assign FlushF     = take | eret | flush_tail;
  assign FlushD     = take | eret | flush_tail;
  assign FlushE     = take | eret | flush_tail;
  assign FlushM     = take | flush_tail;
  assign StallAll   = stall;
  assign PCRedirect = take | eret;
  assign NPC        = take ? HANDLER_ADDR : (eret ? EPC : 32'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_RUN;
      cnt        <= 3'd0;
      ExcCodeOut <= EXC_NONE;
    end else begin
      case (state)
        ST_RUN, ST_DRAIN: begin
          if (take) begin
            ExcCodeOut <= cause;
            cnt        <= FLUSH_LOAD;
            state      <= (FLUSH_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
          end else if (tk) begin
            // tk without take means MDBusy is holding the entry off.
            state <= ST_DRAIN;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
module tb_exc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ExcCodeM;
  logic        IntReq;
  logic        EXL;
  logic        IsEretM;
  logic [31:0] EPC;
  logic        MDBusy;
  logic        EXLSet;
  logic [4:0]  ExcCodeOut;
  logic        EXLClr;
  logic        FlushF, FlushD, FlushE, FlushM;
  logic        StallAll;
  logic        PCRedirect;
  logic [31:0] NPC;

  exc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .ExcCodeM(ExcCodeM), .IntReq(IntReq), .EXL(EXL),
    .IsEretM(IsEretM), .EPC(EPC), .MDBusy(MDBusy), .EXLSet(EXLSet),
    .ExcCodeOut(ExcCodeOut), .EXLClr(EXLClr), .FlushF(FlushF), .FlushD(FlushD),
    .FlushE(FlushE), .FlushM(FlushM), .StallAll(StallAll),
    .PCRedirect(PCRedirect), .NPC(NPC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [44:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] H = 32'h0000_4180;

  // Expected vector layout: {EXLSet, EXLClr, FlushF/D/E/M, StallAll, PCRedirect, NPC, ExcCodeOut}
  task automatic chk(input string n, input logic es, input logic ec, input logic [3:0] fl,
                     input logic st, input logic rd, input logic [31:0] npc, input logic [4:0] eo);
    exp_t e;
    e.name = n;
    e.exp  = {es, ec, fl, st, rd, npc, eo};
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents at mid-cycle against the oldest expectation.
  initial begin
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [44:0] got;
        e   = exp_q.pop_front();
        got = {EXLSet, EXLClr, FlushF, FlushD, FlushE, FlushM, StallAll, PCRedirect, NPC, ExcCodeOut};
        total++;
        if (got !== e.exp) begin
          bad++;
          $display("FAIL %s: got set=%b clr=%b fl=%b st=%b rd=%b npc=%h eo=%0d, want set=%b clr=%b fl=%b st=%b rd=%b npc=%h eo=%0d",
                   e.name, got[44], got[43], got[42:39], got[38], got[37], got[36:5], got[4:0],
                   e.exp[44], e.exp[43], e.exp[42:39], e.exp[38], e.exp[37], e.exp[36:5], e.exp[4:0]);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; ExcCodeM = 5'd4; IntReq = 1'b0; EXL = 1'b0;
    IsEretM = 1'b0; EPC = 32'd0; MDBusy = 1'b0;
    cyc();

    // Reset held with a pending exception: everything quiet
    chk("rst_a", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd31); cyc();
    chk("rst_b", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd31); cyc();

    // First cycle after release takes ExcCode 4
    Reset = 1'b0;
    chk("post_rst_take", 1, 0, 4'b1111, 0, 1, H, 5'd31); cyc();
    ExcCodeM = 5'd31; EXL = 1'b1;
    chk("post_rst_flush", 0, 0, 4'b1111, 0, 0, 32'd0, 5'd4); cyc();
    chk("post_rst_idle", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd4); cyc();

    // Sync exception, 2 flush cycles, single EXLSet
    EXL = 1'b0; ExcCodeM = 5'd12;
    chk("sync_take", 1, 0, 4'b1111, 0, 1, H, 5'd4); cyc();
    EXL = 1'b1; ExcCodeM = 5'd31;
    chk("sync_flush2", 0, 0, 4'b1111, 0, 0, 32'd0, 5'd12); cyc();
    chk("sync_done", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd12); cyc();

    // Nested: EXL=1 masks both exception and interrupt
    ExcCodeM = 5'd8; IntReq = 1'b1;
    chk("nested_ignored", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd12); cyc();

    // Eret returns to EPC, FlushM stays low
    ExcCodeM = 5'd31; IntReq = 1'b0; IsEretM = 1'b1; EPC = 32'h0000_3010;
    chk("eret", 0, 1, 4'b1110, 0, 1, 32'h3010, 5'd12); cyc();
    IsEretM = 1'b0; EXL = 1'b0;
    chk("eret_done", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd12); cyc();

    // Interrupt held off by mult/div for 3 cycles
    IntReq = 1'b1; MDBusy = 1'b1;
    chk("drain_1", 0, 0, 4'b0000, 1, 0, 32'd0, 5'd12); cyc();
    chk("drain_2", 0, 0, 4'b0000, 1, 0, 32'd0, 5'd12); cyc();
    chk("drain_3", 0, 0, 4'b0000, 1, 0, 32'd0, 5'd12); cyc();
    MDBusy = 1'b0;
    chk("drain_take", 1, 0, 4'b1111, 0, 1, H, 5'd12); cyc();
    IntReq = 1'b0; EXL = 1'b1;
    chk("drain_flush2", 0, 0, 4'b1111, 0, 0, 32'd0, 5'd0); cyc();
    chk("drain_done", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd0); cyc();

    // Request withdrawn during DRAIN: no pulse, back to RUN
    EXL = 1'b0; IntReq = 1'b1; MDBusy = 1'b1;
    chk("drop_1", 0, 0, 4'b0000, 1, 0, 32'd0, 5'd0); cyc();
    chk("drop_2", 0, 0, 4'b0000, 1, 0, 32'd0, 5'd0); cyc();
    IntReq = 1'b0;
    chk("drop_exit", 0, 0, 4'b0000, 1, 0, 32'd0, 5'd0); cyc();
    chk("drop_run", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd0); cyc();
    MDBusy = 1'b0;

    // Collision: take beats eret; with EXL=1 the eret wins
    IsEretM = 1'b1; ExcCodeM = 5'd10;
    chk("coll_take", 1, 0, 4'b1111, 0, 1, H, 5'd0); cyc();
    EXL = 1'b1; ExcCodeM = 5'd31;
    chk("coll_flush_ignores_eret", 0, 0, 4'b1111, 0, 0, 32'd0, 5'd10); cyc();
    ExcCodeM = 5'd10;
    chk("coll_exl_eret", 0, 1, 4'b1110, 0, 1, 32'h3010, 5'd10); cyc();
    IsEretM = 1'b0; ExcCodeM = 5'd31; EXL = 1'b0;
    chk("coll_done", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd10); cyc();

    // Reset asserted in the FLUSH cycle
    ExcCodeM = 5'd3;
    chk("rflush_take", 1, 0, 4'b1111, 0, 1, H, 5'd10); cyc();
    Reset = 1'b1; ExcCodeM = 5'd31; EXL = 1'b1;
    chk("rflush_in_reset", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd3); cyc();
    Reset = 1'b0;
    chk("rflush_after", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd31); cyc();
    chk("rflush_run", 0, 0, 4'b0000, 0, 0, 32'd0, 5'd31); cyc();

    cyc(); cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
